// File: rtl/display_reader_pkg.sv
// Shared definitions for the display reader: FSM states, 7-segment patterns
// (active-low gfedcba) and a counter-width helper.
package display_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_CAP  = 2'd3
   } state_t;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Counter width for a modulo-n counter; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/display_reader_if.sv
// RAM read bus between the display reader (master) and the display RAM (slave).
interface display_reader_if #(
   parameter int ADDR_W = 4
) ();
   logic              request;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       valor;
   logic              busy;

   modport master (output request, output addr, output busy, input valor);
   modport slave  (input request, input addr, input busy, output valor);
endinterface

// File: rtl/display_reader_hex_to_7seg.sv
// Combinational nibble to active-low 7-segment (gfedcba) pattern.
module hex_to_7seg
   import display_reader_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_nibble)
         4'h0: o_seg = SEG_0;
         4'h1: o_seg = SEG_1;
         4'h2: o_seg = SEG_2;
         4'h3: o_seg = SEG_3;
         4'h4: o_seg = SEG_4;
         4'h5: o_seg = SEG_5;
         4'h6: o_seg = SEG_6;
         4'h7: o_seg = SEG_7;
         4'h8: o_seg = SEG_8;
         4'h9: o_seg = SEG_9;
         4'hA: o_seg = SEG_A;
         4'hB: o_seg = SEG_B;
         4'hC: o_seg = SEG_C;
         4'hD: o_seg = SEG_D;
         4'hE: o_seg = SEG_E;
         default: o_seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/display_reader.sv
// Periodic RAM word fetch shown as 4 hex digits on a multiplexed 7-seg display.
// Optional macro DISPLAY_BLANK_LEADING_EN blanks leading zero digits 3..1.
module display_reader
   import display_reader_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int FETCH_DIV = CLK_FREQ / 1000,
   parameter int SCAN_DIV  = 12_500,
   parameter int RD_LAT    = 1,
   parameter int ADDR_W    = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [ADDR_W-1:0]    i_sel,
   display_reader_if.master     bus,
   output logic [6:0]           o_seg,
   output logic [3:0]           o_an
);

   localparam int FW = cnt_width(FETCH_DIV);
   localparam int SW = cnt_width(SCAN_DIV);
   localparam int LW = cnt_width(RD_LAT);

   state_t            r_state, w_state_next;
   logic [FW-1:0]     r_fetch_cnt;
   logic [SW-1:0]     r_scan_cnt;
   logic [LW-1:0]     r_lat_cnt, w_lat_next;
   logic [1:0]        r_digit, w_digit_next;
   logic [15:0]       r_data, w_data_next;
   logic              r_pending, w_pending_next;
   logic              r_request, w_request_next;
   logic              r_busy, w_busy_next;
   logic [ADDR_W-1:0] r_addr, w_addr_next;
   logic [6:0]        r_seg;
   logic [3:0]        r_an;

   logic              w_tick;
   logic              w_scan_wrap;
   logic [3:0]        w_nibble;
   logic [6:0]        w_hex_seg;
   logic              w_blank;

   assign w_tick      = (r_fetch_cnt == FW'(FETCH_DIV - 1));
   assign w_scan_wrap = (r_scan_cnt == SW'(SCAN_DIV - 1));

   // The word is captured on the edge that leaves WAIT, so i_valor is sampled
   // RD_LAT+1 edges after the request edge; CAP is the one-cycle turnaround.
   always_comb begin
      w_state_next   = r_state;
      w_lat_next     = r_lat_cnt;
      w_data_next    = r_data;
      w_pending_next = r_pending;
      w_request_next = r_request;
      w_busy_next    = r_busy;
      w_addr_next    = r_addr;
      case (r_state)
         ST_IDLE: begin
            if (w_tick || r_pending) begin
               w_addr_next    = i_sel;
               w_request_next = 1'b1;
               w_busy_next    = 1'b1;
               w_pending_next = 1'b0;
               w_state_next   = ST_REQ;
            end
         end
         ST_REQ: begin
            w_request_next = 1'b0;
            w_lat_next     = '0;
            w_state_next   = ST_WAIT;
         end
         ST_WAIT: begin
            w_lat_next = r_lat_cnt + 1'b1;
            if (r_lat_cnt == LW'(RD_LAT - 1)) begin
               w_data_next  = bus.valor;
               w_busy_next  = 1'b0;
               w_state_next = ST_CAP;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
      // A tick that arrives while a fetch is in flight is remembered once.
      if (w_tick && (r_state != ST_IDLE)) begin
         w_pending_next = 1'b1;
      end
   end

   assign w_digit_next = w_scan_wrap ? (r_digit + 2'd1) : r_digit;
   assign w_nibble     = 4'(r_data >> {w_digit_next, 2'b00});

   hex_to_7seg u_hex (
      .i_nibble (w_nibble),
      .o_seg    (w_hex_seg)
   );

`ifdef DISPLAY_BLANK_LEADING_EN
   logic [3:0] w_upper_zero;
   assign w_upper_zero[0] = 1'b0;
   for (genvar gi = 1; gi < 4; gi++) begin : g_upper_zero
      assign w_upper_zero[gi] = (r_data[15:4*gi] == '0);
   end
   assign w_blank = w_upper_zero[w_digit_next];
`else
   assign w_blank = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_fetch_cnt <= '0;
         r_scan_cnt  <= '0;
         r_lat_cnt   <= '0;
         r_digit     <= 2'd0;
         r_data      <= 16'h0000;
         r_pending   <= 1'b0;
         r_request   <= 1'b0;
         r_busy      <= 1'b0;
         r_addr      <= '0;
         r_an        <= 4'b1110;
         r_seg       <= SEG_0;
      end else begin
         r_state     <= w_state_next;
         r_fetch_cnt <= w_tick ? '0 : r_fetch_cnt + 1'b1;
         r_scan_cnt  <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
         r_lat_cnt   <= w_lat_next;
         r_digit     <= w_digit_next;
         r_data      <= w_data_next;
         r_pending   <= w_pending_next;
         r_request   <= w_request_next;
         r_busy      <= w_busy_next;
         r_addr      <= w_addr_next;
         r_an        <= ~(4'b0001 << w_digit_next);
         r_seg       <= w_blank ? SEG_BLANK : w_hex_seg;
      end
   end

   assign bus.request = r_request;
   assign bus.addr    = r_addr;
   assign bus.busy    = r_busy;
   assign o_seg       = r_seg;
   assign o_an        = r_an;

endmodule

// File: tb/tb_display_reader.sv
// Randomized bench for display_reader: two instances (FETCH_DIV 8/RD_LAT 1 and
// FETCH_DIV 2/RD_LAT 3) against a fetch-schedule and scan reference model.
module tb_display_reader;

   logic       clk;
   logic       rst_n;
   logic [3:0] sel;
   logic       s_rst;
   logic [3:0] s_sel;
   logic       checking_on;
   logic [15:0] ram [16];

   int checks;
   int errors;

   localparam logic [6:0] HEX_TAB [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_model(input logic [15:0] d, input int dig);
      logic [15:0] upper;
      upper = d >> (4 * dig);
`ifdef DISPLAY_BLANK_LEADING_EN
      if (dig > 0 && upper == 16'h0000) return 7'h7F;
`endif
      return HEX_TAB[upper[3:0]];
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      s_rst <= rst_n;
      s_sel <= sel;
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int FD  = (gi == 0) ? 8 : 2;
      localparam int LAT = (gi == 0) ? 1 : 3;

      display_reader_if #(.ADDR_W(4)) u_bus ();
      logic [6:0] seg;
      logic [3:0] an;

      display_reader #(
         .FETCH_DIV (FD),
         .SCAN_DIV  (4),
         .RD_LAT    (LAT),
         .ADDR_W    (4)
      ) u_dut (
         .i_clk   (clk),
         .i_rst_n (rst_n),
         .i_sel   (sel),
         .bus     (u_bus),
         .o_seg   (seg),
         .o_an    (an)
      );

      // RAM: word valid on valor only in the single cycle the reader should sample it.
      logic [16:0] pipe [1:LAT];
      logic [15:0] junk;
      always @(posedge clk) begin
         pipe[1] <= {u_bus.request, ram[u_bus.addr]};
         for (int i = 2; i <= LAT; i++) pipe[i] <= pipe[i-1];
         junk <= 16'($urandom);
      end
      assign u_bus.valor = pipe[LAT][16] ? pipe[LAT][15:0] : junk;

      int k, e0, cap_at, free_at, n_fetch, n_req, n_pend_fetch;
      bit pend, m_req, m_busy, m_in_wait, prev_req;
      logic [3:0]  m_addr;
      logic [15:0] m_data;
      logic [6:0]  m_seg;
      logic [3:0]  m_an;

      initial begin
         n_fetch = 0; n_req = 0; n_pend_fetch = 0; prev_req = 0;
      end

      always @(negedge clk) begin
         if (!s_rst) begin
            k = 0; e0 = -100; cap_at = -1; free_at = 0; pend = 0;
            m_req = 0; m_busy = 0; m_in_wait = 0; m_addr = 0; m_data = 0;
            m_an = 4'b1110; m_seg = 7'h40;
         end else begin
            m_an  = ~(4'b0001 << (((k + 1) / 4) % 4));
            m_seg = seg_model(m_data, ((k + 1) / 4) % 4);
            m_req = 0;
            if (k >= free_at && ((k % FD) == FD - 1 || pend)) begin
               if (pend) n_pend_fetch++;
               e0 = k; cap_at = k + LAT + 1; free_at = k + LAT + 3;
               m_req = 1; m_addr = s_sel; pend = 0; n_fetch++;
            end else if ((k % FD) == FD - 1 && k < free_at) begin
               pend = 1;
            end
            if (k == cap_at) m_data = ram[m_addr];
            m_busy    = (k >= e0 && k < cap_at);
            m_in_wait = (k > e0 && k < cap_at);
            k++;
         end
         if (checking_on) begin
            check_eq($sformatf("req%0d", gi), u_bus.request, m_req);
            check_eq($sformatf("busy%0d", gi), u_bus.busy, m_busy);
            if (m_busy) check_eq($sformatf("addr%0d", gi), u_bus.addr, m_addr);
            check_eq($sformatf("an%0d", gi), an, m_an);
            check_eq($sformatf("seg%0d", gi), seg, m_seg);
            if (prev_req) check_eq($sformatf("req_b2b%0d", gi), u_bus.request, 1'b0);
            prev_req = u_bus.request;
            if (u_bus.request) n_req++;
         end
      end
   end

   task automatic run_cycles(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); #1;
         if (rnd) sel = 4'($urandom);
      end
   endtask

   task automatic wait_an(input logic [3:0] want, output bit ok);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk); #1;
         if (g_inst[0].an == want) ok = 1;
      end
   endtask

   initial begin
      bit ok;
      checks = 0; errors = 0; checking_on = 0;
      rst_n = 1'b0; sel = 4'd3;
      for (int i = 0; i < 16; i++) ram[i] = 16'($urandom);
      ram[3] = 16'h1A2F;
      ram[5] = 16'h0005;

      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check_eq("rst_req0", g_inst[0].u_bus.request, 1'b0);
      check_eq("rst_busy0", g_inst[0].u_bus.busy, 1'b0);
      check_eq("rst_an0", g_inst[0].an, 4'b1110);
      check_eq("rst_seg0", g_inst[0].seg, 7'b1000000);
      check_eq("rst_an1", g_inst[1].an, 4'b1110);
      check_eq("rst_seg1", g_inst[1].seg, 7'b1000000);
      $display("reset checked");
      checking_on = 1; rst_n = 1'b1;

      run_cycles(40, 0);
      $display("fetch sel=3 window done, model data %04h", g_inst[0].m_data);
      wait_an(4'b1110, ok);
      check_eq("wait_an0", ok, 1'b1);
      check_eq("dig0_F", g_inst[0].seg, 7'b0001110);
      wait_an(4'b0111, ok);
      check_eq("wait_an3", ok, 1'b1);
      check_eq("dig3_1", g_inst[0].seg, 7'b1111001);

      run_cycles(300, 1);
      $display("random window done, fetches %0d/%0d", g_inst[0].n_fetch, g_inst[1].n_fetch);

      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk); #1;
         if (g_inst[0].m_in_wait) ok = 1;
      end
      check_eq("find_wait", ok, 1'b1);
      rst_n = 1'b0;
      @(negedge clk); #1;
      check_eq("midrst_busy", g_inst[0].u_bus.busy, 1'b0);
      check_eq("midrst_req", g_inst[0].u_bus.request, 1'b0);
      check_eq("midrst_seg", g_inst[0].seg, 7'b1000000);
      rst_n = 1'b1;
      run_cycles(5, 0);
      check_eq("midrst_data0", g_inst[0].seg, 7'b1000000);
      $display("reset mid-fetch done");

      sel = 4'd5;
      run_cycles(60, 0);
      wait_an(4'b1110, ok);
      check_eq("wait_b0", ok, 1'b1);
      check_eq("dig0_5", g_inst[0].seg, 7'b0010010);
      wait_an(4'b1101, ok);
      check_eq("wait_b1", ok, 1'b1);
`ifdef DISPLAY_BLANK_LEADING_EN
      check_eq("dig1_blank", g_inst[0].seg, 7'b1111111);
`else
      check_eq("dig1_zero", g_inst[0].seg, 7'b1000000);
`endif
      $display("leading digit window done");

      run_cycles(200, 1);
      check_eq("nreq0", g_inst[0].n_req, g_inst[0].n_fetch);
      check_eq("nreq1", g_inst[1].n_req, g_inst[1].n_fetch);
      check_eq("pend_fetch1", g_inst[1].n_pend_fetch > 0, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
